cache_fill: RTL and testbench
=============================

# cache_fill

Direct-mapped, read-only cache between the CPU fetch/load port and the line-granular memory port. A hit returns a 32-bit word in the same cycle. A miss stalls the CPU and issues a line request on PAddr. The block holds PAddr stable until the memory raises En, then captures the `CACHE_LINE_LEN`-bit line.

## Interface
- `LINES`, default 8: number of cache lines; power of two; index width IW = log2(LINES).
- `Clk  in  1`: clock; all state updates on posedge.
- `Rst  in  1`: reset, asynchronous, active-low.
- `Req  in  1`: CPU access request.
- `Addr  in  32`: CPU byte address; word select is Addr[3:2].
- `Flush  in  1`: invalidates all lines at the next edge.
- `Data  out  32`: selected word of the hit line; valid while Req && !Stall.
- `Stall  out  1`: high while Req misses or a fill is in progress.
- `PAddr  out  32`: line-aligned memory address, registered, low 4 bits always 0.
- `Val  in  CACHE_LINE_LEN`: line data from memory.
- `En  in  1`: line-ready strobe; valid only while PAddr has been held constant.

## Operation
- Address split: offset [3:0]; index [4+IW-1:4]; tag [31:4+IW]. A line is 128 bits holding 4 words, with word 0 in bits [31:0].
- Hit = Req && valid[idx] && tag[idx]==Addr tag. Data = word Addr[3:2] of data[idx], combinational.
- Stall = (state != IDLE) || (Req && !hit).
- Memory counts stability of PAddr. En asserts only after PAddr has been unchanged for several edges, and may pulse again later. En is ignored outside FILL.
- Reuse rule: if a new line address equals the current PAddr, the memory stability counter has not restarted. The controller must first drive a different address.
- States:
  - IDLE
    - Req && !hit && missline != PAddr: latch missline={Addr[31:4],4'b0}, PAddr<=missline, go to FILL.
    - Req && !hit && missline == PAddr: PAddr<=missline ^ 32'h10, go to PARK.
  - PARK: PAddr<=missline, go to FILL. Always exactly one cycle.
  - FILL
    - Wait for En.
    - On En: data[idx]<=Val, tag[idx]<=missline tag, valid[idx]<=1, go to IDLE.
    - PAddr keeps its value in IDLE; no new request is issued.
- The CPU holds Req/Addr while Stall is high. If Req drops mid-fill, the fill still completes and installs; there is no abort.
- Flush: clears all valid bits at the edge.
  - A fill in progress continues to completion.
  - If Flush and the En capture land on the same edge, Flush wins: data and tag are written, valid[idx] stays 0.
- Reset, from any state, including mid-fill:
  - state=IDLE, valid all 0, PAddr=32'h0, missline=0.
  - Data is don't-care and Stall=0 while Req=0.
  - A first miss to line address 0 after reset therefore goes through PARK.

## Timing
- Hit: zero wait; Data is valid in the same cycle as Req.
- Miss, with a memory that raises En N edges after the PAddr change:
  - Miss detected in cycle 0; PAddr changes at edge 0.
  - Capture happens on the first En-high edge.
  - Hit occurs in the cycle after capture.
- Team memory model: En appears in cycle 5, so Stall is high in cycles 0–5 (6 cycles) and the hit occurs in cycle 6. The PARK path adds 1 cycle (7).
- PAddr changes only on the IDLE→FILL, IDLE→PARK and PARK→FILL edges. In FILL it is constant every cycle.

## Structure
- Define.v gains:
  - `CACHE_LINE_LEN` (128, existing).
  - `CACHE_WORDS` (4).
  - State encodings `CF_IDLE`, `CF_PARK`, `CF_FILL` (2 bits).
- One sub-module, `cache_line_array`:
  - Holds valid/tag/data storage.
  - Combinational read port by index.
  - One write port (idx, tag, line, valid_bit).
  - Synchronous Flush clear.
  - Async reset of valid bits.
- The FSM and hit logic stay in `cache_fill`.

## Test plan
- Reset, then Req with Addr=32'h0000_0104:
  - Miss; line address 0x100 ≠ 0 so no PARK; PAddr=0x100 at edge 0.
  - Model returns line 0x100; Stall high 6 cycles.
  - Data=word1 (bits[63:32]) in cycle 6.
- After the previous fill, Req Addr=32'h0000_010C → hit in the same cycle, Data=word3, PAddr unchanged.
- Reset, then Req Addr=32'h0000_0008 (line 0 == reset PAddr):
  - PAddr sequence 0x10 then 0x00.
  - Stall 7 cycles; Data=word2 of line 0.
- Conflict: fill 0x100, then Req 0x180 (same index for LINES=8):
  - Miss, refill, line replaced.
  - A later Req 0x100 misses again.
- Flush asserted on the same edge as En capture of 0x200 → the following Req 0x200 misses and refills.
- Rst low during FILL (cycle 3):
  - Stall=0 and PAddr=0 immediately.
  - After release, the prior miss line is invalid and a Req to it re-misses.

Source files
------------

// File: rtl/cache_fill_pkg.sv
// Shared constants, state encoding and line helpers for the read-only fill cache.
package cache_fill_pkg;

    localparam int CACHE_LINE_LEN = 128;
    localparam int CACHE_WORDS    = 4;

    typedef enum logic [1:0] {
        CF_IDLE = 2'd0,
        CF_PARK = 2'd1,
        CF_FILL = 2'd2
    } cf_state_t;

    function automatic logic [31:0] line_word(input logic [CACHE_LINE_LEN-1:0] line,
                                              input logic [1:0] sel);
        case (sel)
            2'd0:    line_word = line[31:0];
            2'd1:    line_word = line[63:32];
            2'd2:    line_word = line[95:64];
            2'd3:    line_word = line[127:96];
            default: line_word = line[31:0];
        endcase
    endfunction

endpackage

// File: rtl/cache_fill_if.sv
// CPU-side and memory-side bus of the fill cache; slave is the cache, master drives it.
interface cache_fill_if;
    import cache_fill_pkg::*;

    logic                      Req;
    logic [31:0]               Addr;
    logic                      Flush;
    logic [31:0]               Data;
    logic                      Stall;
    logic [31:0]               PAddr;
    logic [CACHE_LINE_LEN-1:0] Val;
    logic                      En;

    modport slave  (input Req, Addr, Flush, Val, En, output Data, Stall, PAddr);
    modport master (output Req, Addr, Flush, Val, En, input Data, Stall, PAddr);

endinterface

// File: rtl/cache_line_array.sv
// Valid/tag/data storage: combinational read by index, one write port, flush clears valids.
module cache_line_array
    import cache_fill_pkg::*;
#(
    parameter int LINES = 8,
    parameter int TW    = 25
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      flush,
    input  logic [$clog2(LINES)-1:0]  rd_idx,
    output logic                      rd_valid,
    output logic [TW-1:0]             rd_tag,
    output logic [CACHE_LINE_LEN-1:0] rd_line,
    input  logic                      wr_en,
    input  logic [$clog2(LINES)-1:0]  wr_idx,
    input  logic [TW-1:0]             wr_tag,
    input  logic [CACHE_LINE_LEN-1:0] wr_line,
    input  logic                      wr_valid
);
    logic [LINES-1:0]          valid_r;
    logic [TW-1:0]             tag_r  [LINES];
    logic [CACHE_LINE_LEN-1:0] data_r [LINES];

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_line  = data_r[rd_idx];

    // Valid bits: flush beats a simultaneous install so the line stays invalid.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            valid_r <= '0;
        end else if (flush) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= wr_valid;
        end
    end

    // Tag and line payload are written even when a flush hides them.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_line;
        end
    end

endmodule

// File: rtl/cache_fill.sv
// Direct-mapped read-only cache: same-cycle hits, line fill over a stability-counted memory port.
module cache_fill
    import cache_fill_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    cache_fill_if.slave bus
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 28 - IW;

    cf_state_t                 state_r, state_s;
    logic [31:0]               paddr_r, paddr_s;
    logic [27:0]               missline_r, missline_s;
    logic [27:0]               req_line_s;
    logic [IW-1:0]             rd_idx_s;
    logic [TW-1:0]             rd_tag_s;
    logic [CACHE_LINE_LEN-1:0] rd_line_s;
    logic                      rd_valid_s;
    logic                      hit_s;
    logic                      wr_en_s;
    logic                      unused_s;

    assign req_line_s = bus.Addr[31:4];
    assign rd_idx_s   = req_line_s[IW-1:0];
    assign unused_s   = ^bus.Addr[1:0];

    assign hit_s     = bus.Req && rd_valid_s && (rd_tag_s == req_line_s[27:IW]);
    assign bus.Data  = line_word(rd_line_s, bus.Addr[3:2]);
    assign bus.Stall = (state_r != CF_IDLE) || (bus.Req && !hit_s);
    assign bus.PAddr = paddr_r;
    assign wr_en_s   = (state_r == CF_FILL) && bus.En;

    cache_line_array #(
        .LINES (LINES),
        .TW    (TW)
    ) u_array (
        .Clk      (Clk),
        .Rst      (Rst),
        .flush    (bus.Flush),
        .rd_idx   (rd_idx_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_line  (rd_line_s),
        .wr_en    (wr_en_s),
        .wr_idx   (missline_r[IW-1:0]),
        .wr_tag   (missline_r[27:IW]),
        .wr_line  (bus.Val),
        .wr_valid (1'b1)
    );

    // Controller state, memory address and the line being fetched.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r    <= CF_IDLE;
            paddr_r    <= 32'h0;
            missline_r <= 28'h0;
        end else begin
            state_r    <= state_s;
            paddr_r    <= paddr_s;
            missline_r <= missline_s;
        end
    end

    // Next state: a miss to the address already on PAddr parks elsewhere first so
    // the memory restarts its stability count.
    always_comb begin
        state_s    = state_r;
        paddr_s    = paddr_r;
        missline_s = missline_r;
        case (state_r)
            CF_IDLE: begin
                if (bus.Req && !hit_s) begin
                    missline_s = req_line_s;
                    if (req_line_s != paddr_r[31:4]) begin
                        paddr_s = {req_line_s, 4'h0};
                        state_s = CF_FILL;
                    end else begin
                        paddr_s = {req_line_s, 4'h0} ^ 32'h10;
                        state_s = CF_PARK;
                    end
                end else begin
                    state_s = CF_IDLE;
                end
            end
            CF_PARK: begin
                paddr_s = {missline_r, 4'h0};
                state_s = CF_FILL;
            end
            CF_FILL: begin
                if (bus.En) begin
                    state_s = CF_IDLE;
                end else begin
                    state_s = CF_FILL;
                end
            end
            default: begin
                state_s = CF_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill.sv
// Directed bench for cache_fill with a memory that raises En five cycles after PAddr settles.
module tb_cache_fill;
    import cache_fill_pkg::*;

    logic Clk = 1'b0;
    logic Rst;
    int   checks   = 0;
    int   failures = 0;
    int   mem_cnt  = 0;
    logic [31:0] mem_prev = 32'h0;
    int   n;

    cache_fill_if bus ();

    cache_fill #(.LINES(8)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Line content: word i = {8'hA0+i, PAddr[23:0]}
    assign bus.Val = {8'hA3, bus.PAddr[23:0], 8'hA2, bus.PAddr[23:0],
                      8'hA1, bus.PAddr[23:0], 8'hA0, bus.PAddr[23:0]};

    // Memory stability counter, observed mid-cycle.
    always @(negedge Clk) begin
        if (bus.PAddr !== mem_prev) begin
            mem_cnt = 1;
        end else if (mem_cnt < 1000) begin
            mem_cnt = mem_cnt + 1;
        end
        mem_prev = bus.PAddr;
        bus.En = (mem_cnt >= 5);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic wait_unstall(output int cnt);
        cnt = 0;
        while (bus.Stall === 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
    endtask

    task automatic access(input logic [31:0] a, input int exp_stall,
                          input logic [31:0] exp_data, input string tag);
        int c;
        bus.Req  = 1'b1;
        bus.Addr = a;
        #1;
        wait_unstall(c);
        chk({tag, " stall_cycles"}, c, exp_stall);
        chk({tag, " data"}, bus.Data, exp_data);
    endtask

    initial begin
        Rst       = 1'b0;
        bus.Req   = 1'b0;
        bus.Addr  = 32'h0;
        bus.Flush = 1'b0;
        bus.En    = 1'b0;
        tick();
        tick();
        chk("reset stall", {31'h0, bus.Stall}, 32'h0);
        chk("reset paddr", bus.PAddr, 32'h0);
        Rst = 1'b1;
        tick();

        // Plain miss, then same-line hit
        access(32'h0000_0104, 6, 32'hA100_0100, "miss104");
        chk("miss104 paddr", bus.PAddr, 32'h0000_0100);
        access(32'h0000_010C, 0, 32'hA300_0100, "hit10c");
        chk("hit10c paddr", bus.PAddr, 32'h0000_0100);

        // Miss to line 0 right after reset takes the PARK detour
        bus.Req = 1'b0;
        Rst     = 1'b0;
        #1;
        chk("rst2 stall", {31'h0, bus.Stall}, 32'h0);
        chk("rst2 paddr", bus.PAddr, 32'h0);
        tick();
        Rst = 1'b1;
        tick();
        bus.Req  = 1'b1;
        bus.Addr = 32'h0000_0008;
        #1;
        chk("park stall0", {31'h0, bus.Stall}, 32'h1);
        tick();
        chk("park addr", bus.PAddr, 32'h0000_0010);
        tick();
        chk("park fill addr", bus.PAddr, 32'h0000_0000);
        wait_unstall(n);
        chk("park stall_cycles", n + 2, 7);
        chk("park data", bus.Data, 32'hA200_0000);

        // Conflict on index 0
        access(32'h0000_0100, 6, 32'hA000_0100, "conf100");
        access(32'h0000_0180, 6, 32'hA000_0180, "conf180");
        access(32'h0000_0184, 0, 32'hA100_0180, "hit184");
        access(32'h0000_0100, 6, 32'hA000_0100, "remiss100");

        // Flush on the capture edge of 0x200
        bus.Addr = 32'h0000_0200;
        #1;
        tick();
        chk("flush paddr", bus.PAddr, 32'h0000_0200);
        n = 0;
        do begin
            @(negedge Clk);
            #1;
            n++;
        end while (bus.En !== 1'b1 && n < 20);
        chk("flush en_seen", {31'h0, bus.En}, 32'h1);
        bus.Flush = 1'b1;
        tick();
        bus.Flush = 1'b0;
        #1;
        chk("flush wins stall", {31'h0, bus.Stall}, 32'h1);
        wait_unstall(n);
        chk("flush refill stall_cycles", n, 7);
        chk("flush refill data", bus.Data, 32'hA000_0200);

        // Reset in the middle of a fill
        bus.Addr = 32'h0000_0304;
        #1;
        tick();
        tick();
        tick();
        Rst     = 1'b0;
        bus.Req = 1'b0;
        #1;
        chk("midfill rst stall", {31'h0, bus.Stall}, 32'h0);
        chk("midfill rst paddr", bus.PAddr, 32'h0);
        tick();
        Rst = 1'b1;
        tick();
        access(32'h0000_0304, 6, 32'hA100_0300, "after_rst304");

        bus.Req = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
